// File: rtl/id_exe_stage_reg_if.sv
// id_exe_stage_reg_if: the bus between ID, the ID->EXE register and EXE.
//   master : ID/hazard-context side. It drives the decoded id_* fields, the
//            flush/freeze/forwarding controls and the MEM-stage producer
//            info. It reads ex_*, hazard_stall and stall_cnt.
//   slave  : the ID->EXE register itself.
interface id_exe_stage_reg_if #(
  parameter int PAYLOAD_W = 96,
  parameter int CNT_W     = 16
);
  logic                 flush;
  logic                 freeze_ext;
  logic                 fw_en;
  logic                 id_valid;
  logic [3:0]           id_src1;
  logic [3:0]           id_src2;
  logic                 id_two_src;
  logic [3:0]           id_dest;
  logic                 id_wb_en;
  logic                 id_mem_r_en;
  logic                 id_mem_w_en;
  logic [3:0]           id_exe_cmd;
  logic [PAYLOAD_W-1:0] id_payload;
  logic [3:0]           mem_dest;
  logic                 mem_wb_en;

  logic                 ex_valid;
  logic [3:0]           ex_src1;
  logic [3:0]           ex_src2;
  logic [3:0]           ex_dest;
  logic                 ex_wb_en;
  logic                 ex_mem_r_en;
  logic                 ex_mem_w_en;
  logic [3:0]           ex_exe_cmd;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic                 hazard_stall;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output flush, freeze_ext, fw_en, id_valid, id_src1, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
           id_payload, mem_dest, mem_wb_en,
    input  ex_valid, ex_src1, ex_src2, ex_dest, ex_wb_en, ex_mem_r_en,
           ex_mem_w_en, ex_exe_cmd, ex_payload, hazard_stall, stall_cnt
  );

  modport slave (
    input  flush, freeze_ext, fw_en, id_valid, id_src1, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
           id_payload, mem_dest, mem_wb_en,
    output ex_valid, ex_src1, ex_src2, ex_dest, ex_wb_en, ex_mem_r_en,
           ex_mem_w_en, ex_exe_cmd, ex_payload, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with built-in RAW hazard
// detection and a saturating bubble counter.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active low
//   bus   : id_exe_stage_reg_if.slave
//           in : flush, freeze_ext, fw_en, id_*, mem_dest, mem_wb_en
//           out: ex_* (registered EXE copies), hazard_stall (combinational),
//                stall_cnt (bubbles inserted, saturating)
module id_exe_stage_reg #(
  parameter int PAYLOAD_W = 96,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  id_exe_stage_reg_if.slave bus
);

  typedef struct packed {
    logic                 valid;
    logic [3:0]           src1;
    logic [3:0]           src2;
    logic [3:0]           dest;
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic [3:0]           exe_cmd;
    logic [PAYLOAD_W-1:0] payload;
  } ex_t;

  ex_t              ex_q, ex_d, id_pkt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m1, m2, raw_ex, raw_mem, hazard;

  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = bus.id_valid;
    id_pkt.src1     = bus.id_src1;
    id_pkt.src2     = bus.id_src2;
    id_pkt.dest     = bus.id_dest;
    id_pkt.wb_en    = bus.id_wb_en;
    id_pkt.mem_r_en = bus.id_mem_r_en;
    id_pkt.mem_w_en = bus.id_mem_w_en;
    id_pkt.exe_cmd  = bus.id_exe_cmd;
    id_pkt.payload  = bus.id_payload;
  end

  // R0 gets no special treatment. A bubble can never match because ex_valid
  // gates the EXE-side term.
  always_comb begin
    m1      = (bus.id_src1 == ex_q.dest) |
              (bus.id_two_src & (bus.id_src2 == ex_q.dest));
    m2      = (bus.id_src1 == bus.mem_dest) |
              (bus.id_two_src & (bus.id_src2 == bus.mem_dest));
    raw_ex  = ex_q.valid & ex_q.wb_en & m1;
    raw_mem = bus.mem_wb_en & m2;
    // With forwarding, only a load in EXE cannot be bypassed in time.
    hazard  = bus.id_valid & ~bus.flush &
              (bus.fw_en ? (raw_ex & ex_q.mem_r_en) : (raw_ex | raw_mem));
  end

  // Priority: flush > freeze_ext > hazard > load. While frozen, hazard_stall
  // can still be high, but nothing is counted until the freeze drops.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.freeze_ext) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d = id_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_src1      = ex_q.src1;
  assign bus.ex_src2      = ex_q.src2;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_wb_en     = ex_q.wb_en;
  assign bus.ex_mem_r_en  = ex_q.mem_r_en;
  assign bus.ex_mem_w_en  = ex_q.mem_w_en;
  assign bus.ex_exe_cmd   = ex_q.exe_cmd;
  assign bus.ex_payload   = ex_q.payload;
  assign bus.hazard_stall = hazard;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Bench for id_exe_stage_reg: directed scenarios followed by random traffic,
// all checked against a behavioural model of the EXE slot.
module tb_id_exe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_exe_stage_reg_if #(.PAYLOAD_W(96), .CNT_W(16)) bus ();
  id_exe_stage_reg_if #(.PAYLOAD_W(96), .CNT_W(2))  bus2 ();

  // Second instance shares every input; only its narrow counter differs.
  assign bus2.flush       = bus.flush;
  assign bus2.freeze_ext  = bus.freeze_ext;
  assign bus2.fw_en       = bus.fw_en;
  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_src1     = bus.id_src1;
  assign bus2.id_src2     = bus.id_src2;
  assign bus2.id_two_src  = bus.id_two_src;
  assign bus2.id_dest     = bus.id_dest;
  assign bus2.id_wb_en    = bus.id_wb_en;
  assign bus2.id_mem_r_en = bus.id_mem_r_en;
  assign bus2.id_mem_w_en = bus.id_mem_w_en;
  assign bus2.id_exe_cmd  = bus.id_exe_cmd;
  assign bus2.id_payload  = bus.id_payload;
  assign bus2.mem_dest    = bus.mem_dest;
  assign bus2.mem_wb_en   = bus.mem_wb_en;

  id_exe_stage_reg #(.PAYLOAD_W(96), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  id_exe_stage_reg #(.PAYLOAD_W(96), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0, passes = 0, fails = 0;
  bit track_mem = 0;

  // Model of the instruction sitting in EXE.
  bit          m_valid, m_wb, m_mr, m_mw;
  logic [3:0]  m_src1, m_src2, m_dest, m_cmd;
  logic [95:0] m_pay;
  int          m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_bubble();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_src1 = 0; m_src2 = 0; m_dest = 0; m_cmd = 0; m_pay = '0;
  endtask

  task automatic m_reset();
    m_bubble();
    m_cnt = 0; m_cnt2 = 0;
  endtask

  function automatic bit reads(input logic [3:0] r);
    return (bus.id_src1 == r) || (bus.id_two_src && bus.id_src2 == r);
  endfunction

  function automatic bit m_hz();
    bit ex_prod, mem_prod;
    ex_prod  = m_valid && m_wb && reads(m_dest);
    mem_prod = bus.mem_wb_en && reads(bus.mem_dest);
    if (!bus.id_valid || bus.flush) return 0;
    if (bus.fw_en) return ex_prod && m_mr;
    return ex_prod || mem_prod;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_hz"},    bus.hazard_stall, m_hz());
    chk({tag, "_valid"}, bus.ex_valid,     m_valid);
    chk({tag, "_src1"},  bus.ex_src1,      m_src1);
    chk({tag, "_src2"},  bus.ex_src2,      m_src2);
    chk({tag, "_dest"},  bus.ex_dest,      m_dest);
    chk({tag, "_wb"},    bus.ex_wb_en,     m_wb);
    chk({tag, "_mr"},    bus.ex_mem_r_en,  m_mr);
    chk({tag, "_mw"},    bus.ex_mem_w_en,  m_mw);
    chk({tag, "_cmd"},   bus.ex_exe_cmd,   m_cmd);
    chk({tag, "_pay"},   bus.ex_payload,   m_pay);
    chk({tag, "_cnt"},   bus.stall_cnt,    m_cnt);
    chk({tag, "_cnt2"},  bus2.stall_cnt,   m_cnt2);
  endtask

  // One clock: check at negedge, advance the model, step past the edge.
  task automatic cycle(input string tag);
    bit hz, pv, pwb;
    logic [3:0] pd;
    @(negedge clk);
    check_model(tag);
    hz = m_hz();
    pv = m_valid; pwb = m_wb; pd = m_dest;
    if (bus.flush) m_bubble();
    else if (bus.freeze_ext) begin end
    else if (hz) begin
      m_bubble();
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
    end else begin
      m_valid = bus.id_valid; m_wb = bus.id_wb_en; m_mr = bus.id_mem_r_en;
      m_mw = bus.id_mem_w_en; m_src1 = bus.id_src1; m_src2 = bus.id_src2;
      m_dest = bus.id_dest; m_cmd = bus.id_exe_cmd; m_pay = bus.id_payload;
    end
    @(posedge clk); #1;
    if (track_mem) begin
      bus.mem_dest  = pd;
      bus.mem_wb_en = pv & pwb;
    end
  endtask

  task automatic id(input bit v, input logic [3:0] s1, input logic [3:0] s2, input bit two,
                    input logic [3:0] d, input bit wb, input bit mr, input bit mw,
                    input logic [3:0] cmd);
    bus.id_valid = v; bus.id_src1 = s1; bus.id_src2 = s2; bus.id_two_src = two;
    bus.id_dest = d; bus.id_wb_en = wb; bus.id_mem_r_en = mr; bus.id_mem_w_en = mw;
    bus.id_exe_cmd = cmd; bus.id_payload = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    int e6[5] = '{1, 2, 3, 3, 3};
    bus.flush = 0; bus.freeze_ext = 0; bus.fw_en = 1;
    bus.mem_dest = 0; bus.mem_wb_en = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #2;
    check_model("reset0");
    @(posedge clk); #1 rst = 1;

    // Reset mid-stream clears EXE before any clock edge.
    id(1, 1, 2, 1, 7, 1, 0, 0, 4'h3);
    cycle("t1_load");
    chk("t1_pre_valid", bus.ex_valid, 1);
    #2 rst = 0;
    #1 m_reset();
    chk("t1_rst_valid", bus.ex_valid, 0);
    chk("t1_rst_dest", bus.ex_dest, 0);
    check_model("t1_rst");
    @(posedge clk); #1 rst = 1;

    // Load-use with forwarding: exactly one bubble.
    track_mem = 1; bus.fw_en = 1;
    id(1, 0, 0, 0, 3, 1, 1, 0, 4'h1);
    cycle("t2_ldr");
    id(1, 3, 1, 1, 4, 1, 0, 0, 4'h2);
    #1 chk("t2_hz_on", bus.hazard_stall, 1);
    cycle("t2_stall");
    chk("t2_bubble", bus.ex_valid, 0);
    chk("t2_cnt1", bus.stall_cnt, 1);
    chk("t2_hz_off", bus.hazard_stall, 0);
    cycle("t2_add");
    chk("t2_add_dest", bus.ex_dest, 4);
    chk("t2_add_valid", bus.ex_valid, 1);

    // No forwarding: MEM producer stalls a two-source reader only.
    track_mem = 0; bus.fw_en = 0;
    bus.mem_dest = 2; bus.mem_wb_en = 1;
    id(1, 7, 2, 1, 8, 1, 0, 0, 4'h5);
    #1 chk("t3_hz_two", bus.hazard_stall, 1);
    cycle("t3_stall");
    bus.mem_wb_en = 0;
    #1 chk("t3_hz_gone", bus.hazard_stall, 0);
    cycle("t3_sub");
    bus.mem_dest = 2; bus.mem_wb_en = 1;
    id(1, 7, 2, 0, 9, 1, 0, 0, 4'h5);
    #1 chk("t3_hz_one", bus.hazard_stall, 0);
    cycle("t3_one");
    chk("t3_one_dest", bus.ex_dest, 9);

    // flush beats freeze_ext and the hazard.
    bus.fw_en = 1; bus.mem_wb_en = 0;
    id(1, 0, 0, 0, 3, 1, 1, 0, 4'h1);
    cycle("t4_ldr");
    id(1, 3, 0, 0, 5, 1, 0, 0, 4'h2);
    bus.flush = 1; bus.freeze_ext = 1;
    #1 chk("t4_hz", bus.hazard_stall, 0);
    cycle("t4_flush");
    chk("t4_valid", bus.ex_valid, 0);
    chk("t4_cnt", bus.stall_cnt, 2);
    bus.flush = 0; bus.freeze_ext = 0;

    // freeze_ext holds EXE for three edges.
    id(1, 1, 1, 0, 5, 1, 0, 0, 4'h4);
    cycle("t5_load");
    bus.freeze_ext = 1;
    id(1, 6, 6, 1, 10, 1, 0, 1, 4'h9);
    for (int i = 0; i < 3; i++) begin
      cycle("t5_frz");
      chk("t5_hold_dest", bus.ex_dest, 5);
    end
    bus.freeze_ext = 0;
    cycle("t5_rel");
    chk("t5_rel_dest", bus.ex_dest, 10);

    // Counter saturation (narrow instance) after a reset mid-stream.
    #2 rst = 0;
    #1 m_reset();
    chk("t6_rst_cnt", bus.stall_cnt, 0);
    @(posedge clk); #1 rst = 1;
    bus.fw_en = 0; bus.mem_dest = 6; bus.mem_wb_en = 1;
    id(1, 6, 0, 0, 1, 1, 0, 0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      cycle("t6_stall");
      chk("t6_cnt2", bus2.stall_cnt, e6[i]);
      chk("t6_cnt16", bus.stall_cnt, i + 1);
    end

    // Random traffic on a small register set to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.freeze_ext = ($urandom_range(0, 7) == 0);
      bus.fw_en      = $urandom_range(0, 1);
      bus.mem_dest   = 4'($urandom_range(0, 3));
      bus.mem_wb_en  = $urandom_range(0, 1);
      id($urandom_range(0, 4) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
         $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom));
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
